// File: rtl/alu_pkg.sv
// Shared constants for the registered ALU: opcode encodings and default width.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

endpackage

// File: rtl/alu_adder.sv
// Combinational WIDTH-bit adder with carry in/out. A single instance is shared by
// ADD and SUB; the caller inverts operand y and the carry-in for subtraction.
module alu_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  logic [WIDTH:0] sum;

  // Full-width sum; the extra top bit is the carry-out.
  always_comb begin
    sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
  end

  assign s  = sum[WIDTH-1:0];
  assign co = sum[WIDTH];

endmodule

// File: rtl/alu.sv
// Registered 8-bit (WIDTH) ALU: ADD, SUB-with-borrow, AND, OR selected by sel.
// Result and carry/borrow are registered, one cycle after inputs are sampled.
// Optional zero/signed-overflow flags are built in when ALU_FLAGS_EN is defined.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             cout
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  logic             is_sub;
  logic [WIDTH-1:0] add_y;
  logic             add_ci;
  logic [WIDTH-1:0] add_s;
  logic             add_co;

  logic [WIDTH-1:0] out_d, out_q;
  logic             cout_d, cout_q;

  // Subtraction reuses the adder: a - b - cin == a + ~b + ~cin, borrow = ~carry.
  assign is_sub = (sel == OP_SUB);
  assign add_y  = is_sub ? ~b : b;
  assign add_ci = is_sub ? ~cin : cin;

  alu_adder #(.WIDTH(WIDTH)) u_adder (
    .x  (a),
    .y  (add_y),
    .ci (add_ci),
    .s  (add_s),
    .co (add_co)
  );

  // Opcode mux; every code decoded, unknown/default falls back to ADD.
  always_comb begin
    out_d  = add_s;
    cout_d = add_co;
    case (sel)
      OP_ADD: begin
        out_d  = add_s;
        cout_d = add_co;
      end
      OP_SUB: begin
        out_d  = add_s;
        cout_d = ~add_co;
      end
      OP_AND: begin
        out_d  = a & b;
        cout_d = 1'b0;
      end
      OP_OR: begin
        out_d  = a | b;
        cout_d = 1'b0;
      end
      default: begin
        out_d  = add_s;
        cout_d = add_co;
      end
    endcase
  end

  // Output registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      cout_q <= cout_d;
    end
  end

  assign out  = out_q;
  assign cout = cout_q;

`ifdef ALU_FLAGS_EN
  logic zero_d, zero_q;
  logic ovf_d, ovf_q;

  // Two's-complement overflow from operand and result sign bits.
  function automatic logic signed_ovf(input logic sa, input logic sb,
                                      input logic sr, input logic sub);
    if (sub) return (sa != sb) && (sr != sa);
    else     return (sa == sb) && (sr != sa);
  endfunction

  // Flag next-state: zero tracks the next result, ovf only for arithmetic ops.
  always_comb begin
    zero_d = (out_d == '0);
    ovf_d  = 1'b0;
    case (sel)
      OP_ADD:  ovf_d = signed_ovf(a[WIDTH-1], b[WIDTH-1], add_s[WIDTH-1], 1'b0);
      OP_SUB:  ovf_d = signed_ovf(a[WIDTH-1], b[WIDTH-1], add_s[WIDTH-1], 1'b1);
      OP_AND:  ovf_d = 1'b0;
      OP_OR:   ovf_d = 1'b0;
      default: ovf_d = signed_ovf(a[WIDTH-1], b[WIDTH-1], add_s[WIDTH-1], 1'b0);
    endcase
  end

  // Flag registers; reset reflects the cleared (zero) result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b1;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign zero = zero_q;
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed vector table, randomized ops against an arithmetic
// reference model, and a mid-cycle asynchronous reset sequence.
module tb_alu;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a   = 8'h00;
  logic [7:0] b   = 8'h00;
  logic       cin = 1'b0;
  logic [1:0] sel = 2'b00;
  logic [7:0] out;
  logic       cout;
`ifdef ALU_FLAGS_EN
  logic       zero;
  logic       ovf;
`endif

  alu #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sel  (sel),
    .out  (out),
    .cout (cout)
`ifdef ALU_FLAGS_EN
    ,
    .zero (zero),
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] eo;
    logic       ec;
    logic       ez;
    logic       ev;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model from plain integer arithmetic; returns {zero, ovf, cout, out}.
  function automatic logic [10:0] model(input logic [7:0] a_, input logic [7:0] b_,
                                        input logic cin_, input logic [1:0] sel_);
    int ua, ub, ci, sa, sb, r;
    logic [7:0] o;
    logic c, v;
    ua = int'(a_);
    ub = int'(b_);
    ci = cin_ ? 1 : 0;
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    o = 8'h00; c = 1'b0; v = 1'b0;
    case (sel_)
      2'd0: begin
        r = ua + ub + ci;
        o = 8'(r);
        c = (r > 255);
        r = sa + sb + ci;
        v = (r > 127) || (r < -128);
      end
      2'd1: begin
        r = ua - ub - ci;
        o = 8'(r);
        c = (ua < ub + ci);
        r = sa - sb - ci;
        v = (r > 127) || (r < -128);
      end
      2'd2: o = a_ & b_;
      default: o = a_ | b_;
    endcase
    return {(o == 8'h00), v, c, o};
  endfunction

  task automatic drive(input logic [1:0] s, input logic [7:0] x, input logic [7:0] y,
                       input logic c);
    @(negedge clk);
    sel = s; a = x; b = y; cin = c;
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, "_out"}, out, 8'h00);
    check({nm, "_cout"}, {7'd0, cout}, 8'h00);
`ifdef ALU_FLAGS_EN
    check({nm, "_zero"}, {7'd0, zero}, 8'h01);
    check({nm, "_ovf"}, {7'd0, ovf}, 8'h00);
`endif
  endtask

  function automatic vec_t mk(input logic [1:0] s, input logic [7:0] x, input logic [7:0] y,
                              input logic c, input logic [7:0] eo, input logic ec,
                              input logic ez, input logic ev);
    vec_t t;
    t.sel = s; t.a = x; t.b = y; t.cin = c;
    t.eo = eo; t.ec = ec; t.ez = ez; t.ev = ev;
    return t;
  endfunction

  initial begin
    logic [10:0] m;

    tbl[0]  = mk(OP_ADD, 8'h01, 8'h08, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(OP_ADD, 8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(OP_ADD, 8'h81, 8'h80, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1);
    tbl[3]  = mk(OP_SUB, 8'h10, 8'h04, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(OP_SUB, 8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(OP_SUB, 8'h08, 8'h80, 1'b0, 8'h88, 1'b1, 1'b0, 1'b1);
    tbl[6]  = mk(OP_AND, 8'hC0, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tbl[7]  = mk(OP_OR,  8'hC0, 8'h11, 1'b1, 8'hD1, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(OP_ADD, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    tbl[9]  = mk(OP_SUB, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    tbl[10] = mk(OP_SUB, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tbl[11] = mk(OP_ADD, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1);
    tbl[12] = mk(OP_SUB, 8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1);
    tbl[13] = mk(OP_AND, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(OP_OR,  8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);

    // Reset asserted before any clock edge, then held across edges.
    #2 rst = 1'b1;
    #1 check_reset_state("rst_async");
    repeat (2) @(posedge clk);
    #1 check_reset_state("rst_held");
    @(negedge clk) rst = 1'b0;

    // Directed table: each result appears one edge after its inputs.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].cin);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_out", i), out, tbl[i].eo);
      check($sformatf("tbl%0d_cout", i), {7'd0, cout}, {7'd0, tbl[i].ec});
`ifdef ALU_FLAGS_EN
      check($sformatf("tbl%0d_zero", i), {7'd0, zero}, {7'd0, tbl[i].ez});
      check($sformatf("tbl%0d_ovf", i), {7'd0, ovf}, {7'd0, tbl[i].ev});
`endif
    end

    // Back-to-back random ops, opcode changing freely every cycle.
    for (int i = 0; i < 300; i++) begin
      logic [1:0] rs;
      logic [7:0] ra, rb;
      logic rc;
      rs = 2'($urandom_range(3));
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      if (i % 10 == 0) begin
        ra = (i % 20 == 0) ? 8'hFF : 8'h00;
        rb = (i % 30 == 0) ? 8'h00 : rb;
      end
      drive(rs, ra, rb, rc);
      m = model(ra, rb, rc, rs);
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d_out", i), out, m[7:0]);
      check($sformatf("rnd%0d_cout", i), {7'd0, cout}, {7'd0, m[8]});
`ifdef ALU_FLAGS_EN
      check($sformatf("rnd%0d_zero", i), {7'd0, zero}, {7'd0, m[10]});
      check($sformatf("rnd%0d_ovf", i), {7'd0, ovf}, {7'd0, m[9]});
`endif
    end

    // Load a result with carry set, then assert reset between edges.
    drive(OP_ADD, 8'hFF, 8'h02, 1'b0);
    @(posedge clk);
    #1;
    check("pre_rst_out", out, 8'h01);
    check("pre_rst_cout", {7'd0, cout}, 8'h01);
    #2 rst = 1'b1;
    #1 check_reset_state("rst_mid");
    repeat (2) @(posedge clk);
    #1 check_reset_state("rst_mid_held");

    // Release: the next edge captures whatever inputs are present.
    @(negedge clk);
    sel = OP_SUB; a = 8'h03; b = 8'h05; cin = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_out", out, 8'hFE);
    check("post_rst_cout", {7'd0, cout}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
